alu_cmd_sequencer: RTL

Command sequencer that turns a byte stream from the UART receiver into operations on the registered 8-bit/16-bit ALU. It parses command frames, loads operands and the function code, and pulses the ALU enable. It then captures the 16-bit result and streams it to the UART transmitter as two bytes. It sits between uart_rx, the ALU and uart_tx in the system top.

---
 rtl/alu_cmd_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Parses UART command frames, drives the ALU and streams the
//               16-bit result back to the UART transmitter as two bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
   parameter int          DATA_WIDTH  = 8,
   parameter int          FUN_WIDTH   = 4,
   parameter int          OUT_WIDTH   = 16,
   parameter logic [7:0]  OP_FULL     = 8'hCC,
   parameter logic [7:0]  OP_REUSE    = 8'hDD,
   parameter int          RES_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [FUN_WIDTH-1:0]  alu_fun,
   output logic                  alu_en,
   input  logic [OUT_WIDTH-1:0]  alu_out,
   input  logic                  alu_out_vld,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  overrun
);

   localparam int CNT_W = $clog2(RES_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_A    = 3'd1,
      GET_B    = 3'd2,
      GET_FUN  = 3'd3,
      EXEC     = 3'd4,
      WAIT_RES = 3'd5,
      SEND_LO  = 3'd6,
      SEND_HI  = 3'd7
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  a_q, a_d;
   logic [DATA_WIDTH-1:0]  b_q, b_d;
   logic [FUN_WIDTH-1:0]   fun_q, fun_d;
   logic [OUT_WIDTH-1:0]   result_q, result_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   alu_en_q, alu_en_d;
   logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
   logic                   tx_valid_q, tx_valid_d;
   logic                   busy_q, busy_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overrun_q, overrun_d;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      fun_d       = fun_q;
      result_d    = result_q;
      cnt_d       = cnt_q;
      alu_en_d    = 1'b0;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == OP_FULL) begin
                  state_d = GET_A;
               end else if (rx_data == OP_REUSE) begin
                  state_d = GET_FUN;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         GET_A: begin
            if (rx_valid) begin
               a_d     = rx_data;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (rx_valid) begin
               b_d     = rx_data;
               state_d = GET_FUN;
            end
         end
         GET_FUN: begin
            if (rx_valid) begin
               fun_d    = rx_data[FUN_WIDTH-1:0];
               alu_en_d = 1'b1;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            overrun_d = rx_valid;
            cnt_d     = '0;
            state_d   = WAIT_RES;
         end
         WAIT_RES: begin
            overrun_d = rx_valid;
            if (alu_out_vld) begin
               result_d   = alu_out;
               tx_data_d  = alu_out[DATA_WIDTH-1:0];
               tx_valid_d = 1'b1;
               state_d    = SEND_LO;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_W'(RES_TIMEOUT)) begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         SEND_LO: begin
            overrun_d = rx_valid;
            if (tx_ready) begin
               tx_data_d = result_q[OUT_WIDTH-1:DATA_WIDTH];
               state_d   = SEND_HI;
            end
         end
         SEND_HI: begin
            // A byte arriving alongside the final acceptance is still dropped.
            overrun_d = rx_valid;
            if (tx_ready) begin
               tx_data_d  = '0;
               tx_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         fun_q       <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         alu_en_q    <= 1'b0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         fun_q       <= fun_d;
         result_q    <= result_d;
         cnt_q       <= cnt_d;
         alu_en_q    <= alu_en_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_fun   = fun_q;
   assign alu_en    = alu_en_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

`default_nettype wire
